// File: rtl/traffic_pkg.sv
// Shared lane numbering and preemption state encoding for the traffic
// controller slice.
package traffic_pkg;

    localparam int NUM_LANES = 8;

    localparam int LANE_W1 = 7;
    localparam int LANE_W2 = 6;
    localparam int LANE_S1 = 5;
    localparam int LANE_S2 = 4;
    localparam int LANE_E1 = 3;
    localparam int LANE_E2 = 2;
    localparam int LANE_N1 = 1;
    localparam int LANE_N2 = 0;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } preempt_state_t;

endpackage

// File: rtl/lane_debounce.sv
// Per-lane detector debouncer: the level flips only after DEBOUNCE
// consecutive samples disagree with it; rise flags the edge where it goes high.
module lane_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt;
    logic          flip;

    // The flip is decided combinationally so the new level and its rise
    // land on the same edge as the final agreeing sample.
    assign flip = (in != level) && ((int'(cnt) + 1) >= DEBOUNCE);
    assign rise = flip && in;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (in == level) begin
            cnt <= '0;
        end else if (flip) begin
            level <= in;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/emergency_preempt_encoder.sv
// Turns eight debounced emergency detectors into a single round-robin
// preemption grant (emgSignal/emgLane) with bounded hold and a fixed gap.
module emergency_preempt_encoder #(
    parameter int DEBOUNCE = 2,
    parameter int MIN_HOLD = 8,
    parameter int MAX_HOLD = 32,
    parameter int GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reqIn,
    output logic       emgSignal,
    output logic [7:0] emgLane,
    output logic [7:0] pending
);

    import traffic_pkg::*;

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(GAP + 1);

    logic [NUM_LANES-1:0] deb;
    logic [NUM_LANES-1:0] rise;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .in   (reqIn[i]),
            .level(deb[i]),
            .rise (rise[i])
        );
    end

    // First set bit at or above ptr, wrapping 7 -> 0; the downward scan
    // leaves the closest hit as the final assignment.
    function automatic logic [2:0] pickLane(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        pickLane = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) pickLane = idx;
        end
    endfunction

    traffic_pkg::preempt_state_t state, stateNext;
    logic [HW-1:0] holdCnt, holdCntNext;
    logic [GW-1:0] gapCnt, gapCntNext;
    logic [2:0]    rrPtr, rrPtrNext;
    logic [2:0]    sel, selNext;
    logic [2:0]    pick;
    logic          emgSignalNext;
    logic [7:0]    emgLaneNext;
    logic [7:0]    pendingNext;
    logic [7:0]    clearMask;

    always_comb begin
        stateNext     = state;
        holdCntNext   = holdCnt;
        gapCntNext    = gapCnt;
        rrPtrNext     = rrPtr;
        selNext       = sel;
        emgSignalNext = emgSignal;
        emgLaneNext   = emgLane;
        clearMask     = 8'h00;
        pick          = pickLane(pending, rrPtr);

        case (state)
            traffic_pkg::IDLE: begin
                if (pending != 8'h00) begin
                    stateNext     = traffic_pkg::HOLD;
                    selNext       = pick;
                    emgSignalNext = 1'b1;
                    emgLaneNext   = 8'b1 << pick;
                    holdCntNext   = HW'(1);
                    clearMask     = 8'b1 << pick;
                end
            end
            traffic_pkg::HOLD: begin
                if ((holdCnt == HW'(MAX_HOLD)) ||
                    ((holdCnt >= HW'(MIN_HOLD)) && !deb[sel])) begin
                    stateNext     = traffic_pkg::GAP;
                    emgSignalNext = 1'b0;
                    emgLaneNext   = 8'h00;
                    gapCntNext    = GW'(1);
                    rrPtrNext     = sel + 3'd1;
                end else if (holdCnt < HW'(MAX_HOLD)) begin
                    holdCntNext = holdCnt + 1'b1;
                end
            end
            traffic_pkg::GAP: begin
                if (gapCnt >= GW'(GAP)) begin
                    stateNext = traffic_pkg::IDLE;
                end else begin
                    gapCntNext = gapCnt + 1'b1;
                end
            end
            default: begin
                stateNext     = traffic_pkg::IDLE;
                emgSignalNext = 1'b0;
                emgLaneNext   = 8'h00;
            end
        endcase

        // A fresh rise wins over the clear, so a served lane can re-request.
        pendingNext = (pending & ~clearMask) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= traffic_pkg::IDLE;
            holdCnt   <= '0;
            gapCnt    <= '0;
            rrPtr     <= 3'd0;
            sel       <= 3'd0;
            emgSignal <= 1'b0;
            emgLane   <= 8'h00;
            pending   <= 8'h00;
        end else begin
            state     <= stateNext;
            holdCnt   <= holdCntNext;
            gapCnt    <= gapCntNext;
            rrPtr     <= rrPtrNext;
            sel       <= selNext;
            emgSignal <= emgSignalNext;
            emgLane   <= emgLaneNext;
            pending   <= pendingNext;
        end
    end

endmodule

// File: tb/tb_emergency_preempt_encoder.sv
// Scoreboard bench: stimulus pushes expected grants (lane, length, gap) and a
// monitor checks each emgSignal pulse against the head of the queue.
module tb_emergency_preempt_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] reqIn;
    logic       emgSignal;
    logic [7:0] emgLane;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] lane;
        int         len;
        int         gap;
    } grant_t;

    grant_t sb[$];

    emergency_preempt_encoder #(
        .DEBOUNCE(2), .MIN_HOLD(8), .MAX_HOLD(32), .GAP(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqIn    (reqIn),
        .emgSignal(emgSignal),
        .emgLane  (emgLane),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: tracks pulse length, lane stability and the low gap before each grant.
    logic       prevSig = 1'b0;
    logic       tracked = 1'b0;
    logic       laneMoved = 1'b0;
    logic [7:0] startLane = 8'h00;
    int         runLen = 0;
    int         lowLen = 0;

    always @(negedge clk) begin
        grant_t e;
        checks++;
        if ((emgSignal != (emgLane != 8'h00)) || !$onehot0(emgLane)) begin
            errors++;
            $display("[TB] FAIL invariant: emgSignal=%0b emgLane=%h", emgSignal, emgLane);
        end
        if (emgSignal) begin
            if (!prevSig) begin
                runLen    = 1;
                startLane = emgLane;
                laneMoved = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    tracked = 1'b0;
                    $display("[TB] FAIL unexpected grant: lane=%h, none expected", emgLane);
                end else begin
                    tracked = 1'b1;
                    if (sb[0].gap != 0) begin
                        checks++;
                        if (lowLen != sb[0].gap) begin
                            errors++;
                            $display("[TB] FAIL gap before lane %h: got %0d low cycles, expected %0d",
                                     emgLane, lowLen, sb[0].gap);
                        end
                    end
                end
            end else begin
                runLen++;
                if (emgLane != startLane) laneMoved = 1'b1;
            end
            lowLen = 0;
        end else begin
            if (prevSig && tracked) begin
                e = sb.pop_front();
                checks++;
                if (startLane != e.lane || runLen != e.len || laneMoved) begin
                    errors++;
                    $display("[TB] FAIL grant: lane=%h len=%0d moved=%0b, expected lane=%h len=%0d",
                             startLane, runLen, laneMoved, e.lane, e.len);
                end
                tracked = 1'b0;
            end
            lowLen++;
        end
        prevSig = emgSignal;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] v, input int n);
        reqIn = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic expectGrant(input logic [7:0] lane, input int len, input int gap);
        grant_t e;
        e.lane = lane;
        e.len  = len;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || emgSignal) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || emgSignal) begin
            errors++;
            $display("[TB] FAIL %s timeout: %0d grants outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        reqIn = 8'hFF;

        // Reset holds everything quiet even with all detectors high.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset emgSignal", {7'd0, emgSignal}, 8'h00);
            checkOutput("reset emgLane", emgLane, 8'h00);
            checkOutput("reset pending", pending, 8'h00);
        end

        // All lanes latch together: round-robin serves 01..80, each MIN_HOLD long.
        expectGrant(8'h01, 8, 0);
        for (int i = 1; i < 8; i++) expectGrant(8'h01 << i, 8, 5);
        rst = 1'b0;
        applyStimulus(8'hFF, 3);
        checkOutput("all-lane first grant", emgLane, 8'h01);
        checkOutput("all-lane pending after grant", pending, 8'hFE);
        reqIn = 8'h00;
        waitDone("all-lane", 400);
        repeat (5) @(negedge clk);

        // Single lane E1: latency, then MIN_HOLD release, then quiet.
        expectGrant(8'h08, 8, 0);
        applyStimulus(8'h08, 2);
        checkOutput("single pending k+1", pending, 8'h08);
        checkOutput("single emgSignal k+1", {7'd0, emgSignal}, 8'h00);
        applyStimulus(8'h08, 1);
        checkOutput("single emgSignal k+2", {7'd0, emgSignal}, 8'h01);
        checkOutput("single emgLane k+2", emgLane, 8'h08);
        checkOutput("single pending cleared", pending, 8'h00);
        applyStimulus(8'h08, 2);
        reqIn = 8'h00;
        waitDone("single", 60);
        repeat (4) begin
            checkOutput("single gap low", {7'd0, emgSignal}, 8'h00);
            @(negedge clk);
        end

        // One-cycle glitch on S1 never reaches pending.
        applyStimulus(8'h20, 1);
        applyStimulus(8'h00, 10);
        checkOutput("glitch pending", pending, 8'h00);
        checkOutput("glitch emgSignal", {7'd0, emgSignal}, 8'h00);

        // W1 stuck high: one MAX_HOLD grant, no re-request.
        expectGrant(8'h80, 32, 0);
        applyStimulus(8'h80, 100);
        checkOutput("timeout emgSignal", {7'd0, emgSignal}, 8'h00);
        checkOutput("timeout pending", pending, 8'h00);
        reqIn = 8'h00;
        waitDone("timeout", 10);
        repeat (4) @(negedge clk);

        // Three lanes from reset, held high: served 01, 08, 80 at MAX_HOLD.
        rst   = 1'b1;
        reqIn = 8'h89;
        repeat (2) @(negedge clk);
        expectGrant(8'h01, 32, 0);
        expectGrant(8'h08, 32, 5);
        expectGrant(8'h80, 32, 5);
        rst = 1'b0;
        applyStimulus(8'h89, 2);
        checkOutput("simultaneous pending", pending, 8'h89);
        waitDone("simultaneous", 200);
        reqIn = 8'h00;
        repeat (5) @(negedge clk);

        // Reset in the 5th HOLD cycle truncates the grant and drops pending.
        expectGrant(8'h04, 5, 0);
        reqIn = 8'h04;
        n = 0;
        while (!emgSignal && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midreset grant seen", {7'd0, emgSignal}, 8'h01);
        reqIn = 8'h10;
        repeat (4) @(negedge clk);
        checkOutput("midreset pending before", pending, 8'h10);
        rst   = 1'b1;
        reqIn = 8'h00;
        @(negedge clk);
        checkOutput("midreset emgSignal", {7'd0, emgSignal}, 8'h00);
        checkOutput("midreset emgLane", emgLane, 8'h00);
        checkOutput("midreset pending", pending, 8'h00);
        rst = 1'b0;
        expectGrant(8'h40, 8, 0);
        applyStimulus(8'h40, 2);
        checkOutput("post-reset emgSignal k+1", {7'd0, emgSignal}, 8'h00);
        applyStimulus(8'h40, 1);
        checkOutput("post-reset emgLane k+2", emgLane, 8'h40);
        reqIn = 8'h00;
        waitDone("post-reset", 60);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/emergency_preempt_encoder.md
# emergency_preempt_encoder

Drives the `emgSignal` / `emgLane` preemption inputs of the `Breadboard` traffic-light controller from eight raw per-lane emergency-vehicle detectors. Each detector is debounced, and detections are latched as pending requests. One lane is granted at a time by round-robin, and the request is held stable for a bounded window. Sits between the detector pins and `Breadboard`; the controller consumes its outputs unchanged.

## Interface
Parameters:
- `DEBOUNCE`, 2: consecutive equal samples needed to change a lane's debounced state (≥1).
- `MIN_HOLD`, 8: minimum cycles `emgSignal` stays high per grant.
- `MAX_HOLD`, 32: maximum cycles `emgSignal` stays high per grant (`MAX_HOLD` ≥ `MIN_HOLD`).
- `GAP`, 4: cycles `emgSignal` stays low between grants (≥1).

Ports:
- `clk`, input, 1: single system clock; all state changes on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `reqIn`, input, 8: raw detector levels, one bit per lane. Bit order is the `Breadboard` lane-bus order: bit7=W1, 6=W2, 5=S1, 4=S2, 3=E1, 2=E2, 1=N1, 0=N2.
- `emgSignal`, output, 1: preemption active; connects to `Breadboard.emgSignal`.
- `emgLane`, output, 8: one-hot lane being preempted, same bit order; all-zero whenever `emgSignal`=0.
- `pending`, output, 8: latched, not-yet-served requests (debug/verification).

## Operation
- Debounce, per lane:
  - A lane's debounced level `deb[i]` flips after `reqIn[i]` has been sampled at the opposite value on `DEBOUNCE` consecutive edges.
  - Any mismatching sample restarts that lane's count.
- Request latch: a 0→1 transition of `deb[i]` sets `pending[i]`. A level that stays high never re-sets `pending[i]`.
- FSM states:
  - `IDLE`
    - Outputs are 0.
    - If `pending`≠0, select the first set bit searching upward from `rrPtr`, wrapping 7→0.
    - Load `emgLane` with the selected lane, set `emgSignal`=1, `holdCnt`=1, and clear the selected `pending` bit. Go to `HOLD`.
  - `HOLD`
    - Outputs are held constant and `holdCnt` increments.
    - Leave when `holdCnt`==`MAX_HOLD`, or when `holdCnt`≥`MIN_HOLD` and `deb[sel]`=0.
    - On exit: `emgSignal`=0, `emgLane`=0, `gapCnt`=1, `rrPtr`=sel+1 mod 8. Go to `GAP`.
  - `GAP`
    - Outputs are 0 and `gapCnt` increments.
    - At `gapCnt`==`GAP`, go to `IDLE`.
- Boundary conditions:
  - New requests latch into `pending` in every state, including the lane being served if it falls and rises again during `HOLD`.
  - Several lanes becoming pending in the same cycle: the round-robin order decides which is served.
  - Timeout while the detector is still high: no re-request until `deb` falls and rises again.
  - `rst` in any state: returns to `IDLE` on that edge, clears all counters, `pending`, `deb`, outputs, and sets `rrPtr`=0. Any grant in progress is dropped without a gap.
- Widths:
  - `holdCnt` is `$clog2(MAX_HOLD+1)` bits; `gapCnt` is `$clog2(GAP+1)` bits; debounce counters are `$clog2(DEBOUNCE+1)` bits.
  - All counters saturate and never wrap.

## Timing
- All outputs are registered.
- Reset values: `emgSignal`=0, `emgLane`=8'h00, `pending`=8'h00.
- Latency: if `reqIn[i]` is first sampled high at edge k (FSM in `IDLE`, `pending`=0):
  - `deb[i]` and `pending[i]` are high after edge k+DEBOUNCE−1.
  - `emgSignal` is high after edge k+DEBOUNCE.
- Active window: `emgSignal` is high for N cycles, `MIN_HOLD` ≤ N ≤ `MAX_HOLD`, with `emgLane` stable throughout.
- Minimum spacing between grants: exactly `GAP` low cycles, plus 1 `IDLE` cycle.
- Invariant, every cycle: `emgSignal` == (`emgLane`≠0), and `emgLane` has at most one bit set.

## Structure
- Shared package `traffic_pkg`:
  - Lane index constants `LANE_W1`..`LANE_N2` (7..0).
  - `NUM_LANES`=8.
  - State enum `preempt_state_t` {`IDLE`, `HOLD`, `GAP`}.
- Sub-module `lane_debounce` (parameter `DEBOUNCE`; ports `clk`, `rst`, `in`, `level`, `rise`), instantiated 8 times by generate.
- Round-robin priority select lives in the top as a function.

## Test plan
Defaults (DEBOUNCE=2, MIN_HOLD=8, MAX_HOLD=32, GAP=4) unless noted.
- Reset: hold `rst`=1 with `reqIn`=8'hFF for 3 cycles → `emgSignal`=0, `emgLane`=0, `pending`=0 throughout; after release, the first grant is lane bit0 (N2).
- Single lane: `reqIn`=8'b00001000 (E1) held 5 cycles, then 0.
  - `emgSignal` rises 2 edges after the first high sample, with `emgLane`=8'h08.
  - `emgSignal` drops after exactly 8 cycles.
  - `emgSignal` stays low for 4 cycles.
- Glitch: a 1-cycle pulse on `reqIn[5]` → `pending`=0 and `emgSignal` never asserts.
- Timeout: `reqIn[7]` held high for 100 cycles.
  - `emgSignal` is high for exactly 32 cycles, then goes low.
  - No second grant occurs while `reqIn[7]` stays high.
- Simultaneous: `reqIn`=8'b10001001 asserted together from reset → grants served in order 8'h01, 8'h08, 8'h80, each separated by 4 low cycles plus 1 `IDLE` cycle.
- Mid-grant reset: assert `rst` in the 5th `HOLD` cycle → `emgSignal`=0 after that edge and `pending` cleared; a new request is granted with normal latency.
